// File: rtl/ttl_scan_sequencer.sv
// ttl_scan_sequencer: per-block select sequencer feeding a dual 2-to-4
// decoder. Each block walks its address through 0..WIDTH_OUT-1, holding
// each address for DWELL enabled cycles and blanking the enable for BLANK
// cycles between addresses, so address changes never reach enabled outputs.
module ttl_scan_sequencer #(
  parameter int BLOCKS     = 2,
  parameter int WIDTH_OUT  = 4,
  parameter int WIDTH_IN   = $clog2(WIDTH_OUT),
  parameter int DWELL      = 4,
  parameter int BLANK      = 1,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                         Clk,
  input  logic                         Clear,
  input  logic [BLOCKS-1:0]            Run,
  input  logic [BLOCKS-1:0]            Load,
  input  logic [BLOCKS-1:0]            Down,
  input  logic [WIDTH_IN*BLOCKS-1:0]   D_2D,
  output logic [WIDTH_IN*BLOCKS-1:0]   A_2D,
  output logic [BLOCKS-1:0]            Enable_bar,
  output logic [BLOCKS-1:0]            TC
);

  // Phase counter only ever needs to reach the longer of dwell and blank.
  localparam int PHASE_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int PW        = $clog2(PHASE_MAX + 1);

  localparam logic [PW-1:0]       DWELL_LAST = PW'(DWELL - 1);
  localparam logic [PW-1:0]       BLANK_LAST = PW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [WIDTH_IN-1:0] LAST_ADDR  = WIDTH_IN'(WIDTH_OUT - 1);
  localparam logic [WIDTH_IN:0]   ADDR_LIMIT = (WIDTH_IN + 1)'(WIDTH_OUT);

  // Output delays are a board-level timing notion; the registered outputs
  // here change directly on the clock edge. Only their legality is checked.
  if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
    $error("ttl_scan_sequencer: DELAY_RISE/DELAY_FALL must be non-negative");
  end
  if (WIDTH_OUT < 2 || DWELL < 1 || BLANK < 0) begin : g_bad_shape
    $error("ttl_scan_sequencer: need WIDTH_OUT>=2, DWELL>=1, BLANK>=0");
  end

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  for (genvar i = 0; i < BLOCKS; i++) begin : g_block
    state_t              state;
    logic [PW-1:0]       phase;
    logic [WIDTH_IN-1:0] addr;
    logic [WIDTH_IN-1:0] d_val;
    logic [WIDTH_IN-1:0] load_val;
    logic [WIDTH_IN-1:0] next_addr;
    logic                wraps;
    logic                en_bar;
    logic                tc;

    assign d_val    = D_2D[WIDTH_IN*i +: WIDTH_IN];
    assign load_val = ({1'b0, d_val} >= ADDR_LIMIT) ? '0 : d_val;

    // Next address in the selected direction, wrapping at the range ends.
    always_comb begin
      next_addr = addr;
      wraps     = 1'b0;
      if (Down[i]) begin
        wraps     = (addr == '0);
        next_addr = wraps ? LAST_ADDR : addr - 1'b1;
      end else begin
        wraps     = (addr == LAST_ADDR);
        next_addr = wraps ? '0 : addr + 1'b1;
      end
    end

    // Per-block scan FSM; enable and TC are registered alongside the state.
    always_ff @(posedge Clk) begin
      if (Clear) begin
        state  <= IDLE;
        phase  <= '0;
        addr   <= '0;
        en_bar <= 1'b1;
        tc     <= 1'b0;
      end else if (Load[i]) begin
        state  <= IDLE;
        phase  <= '0;
        addr   <= load_val;
        en_bar <= 1'b1;
        tc     <= 1'b0;
      end else begin
        tc <= 1'b0;
        case (state)
          IDLE: begin
            if (Run[i]) begin
              state  <= DRIVE;
              phase  <= '0;
              en_bar <= 1'b0;
            end
          end
          DRIVE: begin
            if (phase == DWELL_LAST) begin
              addr  <= next_addr;
              tc    <= wraps;
              phase <= '0;
              if (BLANK > 0) begin
                state  <= GAP;
                en_bar <= 1'b1;
              end else if (Run[i]) begin
                state  <= DRIVE;
                en_bar <= 1'b0;
              end else begin
                state  <= IDLE;
                en_bar <= 1'b1;
              end
            end else begin
              phase <= phase + 1'b1;
            end
          end
          GAP: begin
            if (phase == BLANK_LAST) begin
              phase <= '0;
              if (Run[i]) begin
                state  <= DRIVE;
                en_bar <= 1'b0;
              end else begin
                state  <= IDLE;
                en_bar <= 1'b1;
              end
            end else begin
              phase <= phase + 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            phase  <= '0;
            en_bar <= 1'b1;
          end
        endcase
      end
    end

    assign A_2D[WIDTH_IN*i +: WIDTH_IN] = addr;
    assign Enable_bar[i]                = en_bar;
    assign TC[i]                        = tc;
  end

endmodule

// File: tb/tb_ttl_scan_sequencer.sv
// tb_ttl_scan_sequencer: scoreboard bench for ttl_scan_sequencer. Three
// instances cover the default shape, a DWELL=1/BLANK=0 shape and a
// WIDTH_OUT=3 shape. Expected per-cycle outputs are queued when stimulus is
// applied and compared as each clock cycle completes.
module tb_ttl_scan_sequencer;

  logic       clk = 1'b0;
  logic       clear;
  logic [1:0] run, load, down;
  logic [3:0] d;
  logic [3:0] a;
  logic [1:0] en_bar, tc;

  logic       run_f, load_f, down_f;
  logic [1:0] d_f, a_f;
  logic       en_f, tc_f;

  logic       run_w, load_w, down_w;
  logic [1:0] d_w, a_w;
  logic       en_w, tc_w;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    string      tag;
    int         cyc;
    int         ch;
    int         blk;
    logic [3:0] val;
  } exp_t;

  exp_t exp_q[$];

  ttl_scan_sequencer dut (
    .Clk(clk), .Clear(clear), .Run(run), .Load(load), .Down(down),
    .D_2D(d), .A_2D(a), .Enable_bar(en_bar), .TC(tc)
  );

  ttl_scan_sequencer #(.BLOCKS(1), .DWELL(1), .BLANK(0)) dut_fast (
    .Clk(clk), .Clear(clear), .Run(run_f), .Load(load_f), .Down(down_f),
    .D_2D(d_f), .A_2D(a_f), .Enable_bar(en_f), .TC(tc_f)
  );

  ttl_scan_sequencer #(.BLOCKS(1), .WIDTH_OUT(3)) dut_w3 (
    .Clk(clk), .Clear(clear), .Run(run_w), .Load(load_w), .Down(down_w),
    .D_2D(d_w), .A_2D(a_w), .Enable_bar(en_w), .TC(tc_w)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Current {address, enable_bar, tc} of one block of one instance.
  function automatic logic [3:0] observe(input int ch, input int blk);
    case (ch)
      0:       return {a[2*blk +: 2], en_bar[blk], tc[blk]};
      1:       return {a_f, en_f, tc_f};
      default: return {a_w, en_w, tc_w};
    endcase
  endfunction

  // Queue one expectation, off cycles from now.
  task automatic pushExp(input string tag, input int ch, input int blk,
                         input int off, input int addr, input bit enb,
                         input bit t);
    exp_t e;
    e.tag = tag;
    e.cyc = cyc + off;
    e.ch  = ch;
    e.blk = blk;
    e.val = {addr[1:0], enb, t};
    exp_q.push_back(e);
  endtask

  // Expected cycles of a continuous scan starting from IDLE with Run held.
  task automatic genScan(input string tag, input int ch, input int blk,
                         input int start_addr, input bit dn, input int n_addr,
                         input int dwell, input int blank, input int width);
    int addr;
    int off;
    bit tc_pend;
    bit wrap;
    addr    = start_addr;
    off     = 1;
    tc_pend = 1'b0;
    for (int s = 0; s < n_addr; s++) begin
      for (int k = 0; k < dwell; k++) begin
        pushExp(tag, ch, blk, off, addr, 1'b0, (k == 0) ? tc_pend : 1'b0);
        off++;
      end
      tc_pend = 1'b0;
      if (dn) begin
        wrap = (addr == 0);
        addr = wrap ? width - 1 : addr - 1;
      end else begin
        wrap = (addr == width - 1);
        addr = wrap ? 0 : addr + 1;
      end
      if (blank > 0) begin
        for (int k = 0; k < blank; k++) begin
          pushExp(tag, ch, blk, off, addr, 1'b1, (k == 0) ? wrap : 1'b0);
          off++;
        end
      end else begin
        tc_pend = wrap;
      end
    end
  endtask

  // Compare and retire every expectation due on the current cycle.
  task automatic checkOutput();
    logic [3:0] obs;
    for (int j = exp_q.size() - 1; j >= 0; j--) begin
      if (exp_q[j].cyc == cyc) begin
        obs = observe(exp_q[j].ch, exp_q[j].blk);
        checks++;
        assert (obs === exp_q[j].val) else begin
          errors++;
          $error("[TB] FAIL %s cyc=%0d ch=%0d blk=%0d {a,enb,tc} got=%b expected=%b",
                 exp_q[j].tag, cyc, exp_q[j].ch, exp_q[j].blk, obs, exp_q[j].val);
        end
        exp_q.delete(j);
      end
    end
  endtask

  // Drive the default instance's inputs.
  task automatic applyStimulus(input bit c, input logic [1:0] r,
                               input logic [1:0] l, input logic [1:0] dn,
                               input logic [3:0] dv);
    clear = c;
    run   = r;
    load  = l;
    down  = dn;
    d     = dv;
  endtask

  // Advance n cycles, sampling 1 ns after each rising edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      checkOutput();
    end
  endtask

  // Directed sequence of scenarios.
  initial begin
    run_f = 0; load_f = 0; down_f = 0; d_f = 0;
    run_w = 0; load_w = 0; down_w = 0; d_w = 0;
    applyStimulus(1, 2'b00, 2'b00, 2'b00, 4'h0);

    $display("[TB] clear for two cycles");
    for (int o = 1; o <= 2; o++) begin
      pushExp("reset_b0", 0, 0, o, 0, 1, 0);
      pushExp("reset_b1", 0, 1, o, 0, 1, 0);
      pushExp("reset_fast", 1, 0, o, 0, 1, 0);
      pushExp("reset_w3", 2, 0, o, 0, 1, 0);
    end
    tick(2);

    $display("[TB] up scan on block 0, two frames");
    applyStimulus(0, 2'b01, 2'b00, 2'b00, 4'h0);
    genScan("scan_up", 0, 0, 0, 1'b0, 8, 4, 1, 4);
    for (int o = 1; o <= 40; o++) pushExp("idle_b1", 0, 1, o, 0, 1, 0);
    tick(40);
    applyStimulus(0, 2'b00, 2'b00, 2'b00, 4'h0);
    pushExp("stop_idle", 0, 0, 1, 0, 1, 0);
    tick(1);

    $display("[TB] load 1 then down scan");
    applyStimulus(0, 2'b00, 2'b01, 2'b00, 4'b0001);
    pushExp("load_d1", 0, 0, 1, 1, 1, 0);
    tick(1);
    applyStimulus(0, 2'b01, 2'b00, 2'b01, 4'h0);
    genScan("scan_down", 0, 0, 1, 1'b1, 4, 4, 1, 4);
    tick(20);
    applyStimulus(0, 2'b00, 2'b00, 2'b00, 4'h0);
    pushExp("down_stop", 0, 0, 1, 1, 1, 0);
    tick(1);

    $display("[TB] run dropped at phase 1");
    applyStimulus(0, 2'b01, 2'b00, 2'b00, 4'h0);
    for (int o = 1; o <= 4; o++) pushExp("drop_dwell", 0, 0, o, 1, 0, 0);
    for (int o = 5; o <= 7; o++) pushExp("drop_after", 0, 0, o, 2, 1, 0);
    tick(2);
    applyStimulus(0, 2'b00, 2'b00, 2'b00, 4'h0);
    tick(5);

    $display("[TB] clear beats load mid-drive");
    applyStimulus(0, 2'b01, 2'b00, 2'b00, 4'h0);
    pushExp("prec_drive", 0, 0, 1, 2, 0, 0);
    pushExp("prec_drive", 0, 0, 2, 2, 0, 0);
    tick(2);
    applyStimulus(1, 2'b01, 2'b01, 2'b00, 4'b0011);
    pushExp("clear_wins", 0, 0, 1, 0, 1, 0);
    pushExp("clear_b1", 0, 1, 1, 0, 1, 0);
    tick(1);

    $display("[TB] load alone mid-gap");
    applyStimulus(0, 2'b01, 2'b00, 2'b00, 4'b0011);
    for (int o = 1; o <= 4; o++) pushExp("pre_gap", 0, 0, o, 0, 0, 0);
    pushExp("pre_gap", 0, 0, 5, 1, 1, 0);
    tick(5);
    applyStimulus(0, 2'b01, 2'b01, 2'b00, 4'b0011);
    pushExp("load_gap", 0, 0, 1, 3, 1, 0);
    tick(1);
    applyStimulus(0, 2'b00, 2'b00, 2'b00, 4'h0);
    pushExp("load_gap_hold", 0, 0, 1, 3, 1, 0);
    tick(1);

    $display("[TB] load on block 1 at end of dwell suppresses wrap");
    applyStimulus(0, 2'b00, 2'b10, 2'b00, 4'b1100);
    pushExp("b1_load3", 0, 1, 1, 3, 1, 0);
    tick(1);
    applyStimulus(0, 2'b10, 2'b00, 2'b00, 4'h0);
    for (int o = 1; o <= 4; o++) begin
      pushExp("b1_drive", 0, 1, o, 3, 0, 0);
      pushExp("b0_indep", 0, 0, o, 3, 1, 0);
    end
    tick(4);
    applyStimulus(0, 2'b10, 2'b10, 2'b00, 4'b1000);
    pushExp("b1_load_end", 0, 1, 1, 2, 1, 0);
    tick(1);
    applyStimulus(0, 2'b00, 2'b00, 2'b00, 4'h0);
    pushExp("b1_hold", 0, 1, 1, 2, 1, 0);
    tick(1);

    $display("[TB] DWELL=1 BLANK=0 instance");
    run_f = 1;
    genScan("fast_scan", 1, 0, 0, 1'b0, 5, 1, 0, 4);
    tick(5);
    run_f = 0;
    pushExp("fast_stop", 1, 0, 1, 1, 1, 0);
    tick(1);

    $display("[TB] WIDTH_OUT=3 instance");
    load_w = 1;
    d_w    = 2'd3;
    pushExp("w3_load_oor", 2, 0, 1, 0, 1, 0);
    tick(1);
    load_w = 0;
    run_w  = 1;
    genScan("w3_scan", 2, 0, 0, 1'b0, 3, 4, 1, 3);
    tick(15);
    run_w = 0;
    pushExp("w3_stop", 2, 0, 1, 0, 1, 0);
    tick(1);
    load_w = 1;
    d_w    = 2'd2;
    pushExp("w3_load_top", 2, 0, 1, 2, 1, 0);
    tick(1);
    load_w = 0;

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_drain leftover=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
